// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_responder
// Purpose  : Responder for the core's data memory port. Accepts a load or
//            store, stalls the core for LATENCY wait states, then commits the
//            access to a word-organised scratchpad and returns load data.
//            Also keeps completed-load and completed-store counters.
// Ports    : clk, rst                    clock, synchronous active-high reset
//            data_memory_address         byte address (word index in
//                                        [ADDR_WIDTH+1:2], other bits ignored)
//            data_memory_write_data      lane-aligned store data
//            data_memory_byte_enable     store lane mask
//            data_memory_write_enable    store request
//            data_memory_read_enable     load request
//            data_memory_read_data       registered load data
//            data_memory_busy            stall request to the core
//            read_count / write_count    completed loads / stores (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
   parameter int ADDR_WIDTH = 12,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_memory_address,
   input  logic [31:0] data_memory_write_data,
   input  logic [3:0]  data_memory_byte_enable,
   input  logic        data_memory_write_enable,
   input  logic        data_memory_read_enable,
   output logic [31:0] data_memory_read_data,
   output logic        data_memory_busy,
   output logic [31:0] read_count,
   output logic [31:0] write_count
);

   localparam logic [3:0] C_LAT_CNT = 4'(LATENCY);
   localparam int         C_DEPTH   = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [31:0]             wdata_q;
   logic [3:0]              be_q;
   logic                    is_store_q;
   logic [31:0]             rdata_q;
   logic [31:0]             rcnt_q;
   logic [31:0]             wcnt_q;
   logic [31:0]             mem_q [C_DEPTH];

   logic req;
   logic accept;
   logic commit;
   logic w_unused_addr;

   assign req    = data_memory_write_enable | data_memory_read_enable;
   // Inputs are only looked at while idle; WAIT/DONE ignore them entirely.
   assign accept = (state_q == S_IDLE) && req;
   // The access happens on the edge that leaves WAIT. Gating with rst makes a
   // reset during WAIT drop the pending store before it touches the array.
   assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0) && !rst;

   // Byte offset and upper address bits do not participate (upper bits alias).
   assign w_unused_addr = ^{data_memory_address[31:ADDR_WIDTH+2],
                            data_memory_address[1:0]};

   // ---------------------------------------------------------------------
   // Next-state and stall logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      data_memory_busy = 1'b0;
      case (state_q)
         S_IDLE: begin
            data_memory_busy = req;
            if (req) begin
               state_d = S_WAIT;
               cnt_d   = C_LAT_CNT;
            end
         end
         S_WAIT: begin
            data_memory_busy = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // A request still held here is not re-accepted until IDLE.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (rst) begin
         data_memory_busy = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // State, capture registers, load data and counters
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         rcnt_q  <= 32'd0;
         wcnt_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            if (is_store_q) begin
               wcnt_q <= wcnt_q + 32'd1;
            end else begin
               rdata_q <= mem_q[idx_q];
               rcnt_q  <= rcnt_q + 32'd1;
            end
         end
      end
   end

   // Capture registers need no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         idx_q      <= data_memory_address[ADDR_WIDTH+1:2];
         wdata_q    <= data_memory_write_data;
         be_q       <= data_memory_byte_enable;
         is_store_q <= data_memory_write_enable;
      end
   end

   // Scratchpad array: never initialised or cleared by reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (commit && is_store_q && be_q[i]) begin
            mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign data_memory_read_data = rdata_q;
   assign read_count            = rcnt_q;
   assign write_count           = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_responder
// Purpose  : Directed self-checking bench for data_memory_responder. One
//            instance at LATENCY=2 and one at LATENCY=0 share clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] addr = '0, wdata = '0;
   logic [3:0]  be = '0;
   logic        we = 1'b0, re = 1'b0;
   logic [31:0] rdata, rcnt, wcnt;
   logic        busy;

   logic [31:0] addr0 = '0, wdata0 = '0;
   logic [3:0]  be0 = '0;
   logic        we0 = 1'b0, re0 = 1'b0;
   logic [31:0] rdata0, rcnt0, wcnt0;
   logic        busy0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut (
      .clk                      (clk),
      .rst                      (rst),
      .data_memory_address      (addr),
      .data_memory_write_data   (wdata),
      .data_memory_byte_enable  (be),
      .data_memory_write_enable (we),
      .data_memory_read_enable  (re),
      .data_memory_read_data    (rdata),
      .data_memory_busy         (busy),
      .read_count               (rcnt),
      .write_count              (wcnt)
   );

   data_memory_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
      .clk                      (clk),
      .rst                      (rst),
      .data_memory_address      (addr0),
      .data_memory_write_data   (wdata0),
      .data_memory_byte_enable  (be0),
      .data_memory_write_enable (we0),
      .data_memory_read_enable  (re0),
      .data_memory_read_data    (rdata0),
      .data_memory_busy         (busy0),
      .read_count               (rcnt0),
      .write_count              (wcnt0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One access on the LATENCY=2 instance. The request is presented for one
   // IDLE cycle only; returns the number of busy cycles. Ends at the negedge
   // of the DONE cycle.
   task automatic access(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m,
                         output int nbusy);
      @(posedge clk); #1;
      we = w; re = r; addr = a; wdata = d; be = m;
      nbusy = 0;
      @(negedge clk);
      while (busy && nbusy < 20) begin
         nbusy++;
         @(posedge clk); #1;
         we = 1'b0; re = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      int        n;
      logic [8:0] pat;

      // ---------------- reset ----------------
      @(posedge clk); #1;
      rst = 1'b1; we = 1'b1; addr = 32'h10;
      @(negedge clk);
      check("busy_in_reset", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      we = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_rdata", rdata, 32'd0);
      check("reset_rcnt", rcnt, 32'd0);
      check("reset_wcnt", wcnt, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);

      // ---------------- basic store / load ----------------
      access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, n);
      check("store_busy_len", n, 32'd4);
      access(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, n);
      check("load_busy_len", n, 32'd4);
      check("load_data", rdata, 32'hDEADBEEF);
      check("wcnt_1", wcnt, 32'd1);
      check("rcnt_1", rcnt, 32'd1);

      // ---------------- byte lanes ----------------
      access(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, n);
      access(1'b1, 1'b0, 32'h20, 32'h000000AA, 4'h1, n);
      access(1'b1, 1'b0, 32'h20, 32'hBB000000, 4'h8, n);
      access(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, n);
      check("lane_merge", rdata, 32'hBB2233AA);
      check("wcnt_4", wcnt, 32'd4);

      // ---------------- aliasing ----------------
      access(1'b1, 1'b0, 32'h4004, 32'h5A5A5A5A, 4'hF, n);
      access(1'b0, 1'b1, 32'h0004, 32'h0, 4'h0, n);
      check("alias_upper", rdata, 32'h5A5A5A5A);
      access(1'b0, 1'b1, 32'h0006, 32'h0, 4'h0, n);
      check("alias_byteoff", rdata, 32'h5A5A5A5A);
      check("rcnt_4", rcnt, 32'd4);

      // ---------------- reset during WAIT ----------------
      access(1'b1, 1'b0, 32'h40, 32'h12345678, 4'hF, n);
      @(posedge clk); #1;
      we = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; be = 4'hF;
      @(negedge clk);
      check("abort_busy_idle", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      we = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("abort_busy_rst", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_rcnt", rcnt, 32'd0);
      check("abort_wcnt", wcnt, 32'd0);
      check("abort_busy_after", {31'd0, busy}, 32'd0);
      access(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, n);
      check("abort_no_write", rdata, 32'h12345678);

      // ---------------- simultaneous enables ----------------
      access(1'b1, 1'b1, 32'h80, 32'h0F0F0F0F, 4'hF, n);
      check("both_wcnt", wcnt, 32'd1);
      check("both_rcnt", rcnt, 32'd1);
      check("both_rdata_hold", rdata, 32'h12345678);
      access(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, n);
      check("both_stored", rdata, 32'h0F0F0F0F);

      // ---------------- zero byte enable ----------------
      access(1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, 4'h0, n);
      check("be0_busy_len", n, 32'd4);
      check("be0_wcnt", wcnt, 32'd2);
      access(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, n);
      check("be0_no_write", rdata, 32'h0F0F0F0F);
      check("rcnt_3", rcnt, 32'd3);

      // ---------------- idle hold ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_rdata", rdata, 32'h0F0F0F0F);

      // ---------------- LATENCY=0, held load ----------------
      @(posedge clk); #1;
      we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h1234ABCD; be0 = 4'hF;
      @(posedge clk); #1;
      we0 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      re0 = 1'b1; addr0 = 32'h0;
      pat = '0;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         pat = {pat[7:0], busy0};
         @(posedge clk); #1;
      end
      re0 = 1'b0;
      @(negedge clk);
      check("lat0_busy_pattern", {23'd0, pat}, {23'd0, 9'b110110110});
      check("lat0_rcnt", rcnt0, 32'd3);
      check("lat0_wcnt", wcnt0, 32'd1);
      check("lat0_rdata", rdata0, 32'h1234ABCD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Absolute time guard so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data memory port. It accepts load/store requests from the backend, stalls the core with `data_memory_busy` for a programmable number of wait states, and commits the access to an internal word-organised scratchpad. It also returns load data and keeps completion counters. It sits between the core and the on-chip data RAM and serves as both the synthesizable scratchpad and the bench model for exercising the core's stall path.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: word-address bits; array depth is 2^ADDR_WIDTH words (16 KiB at the default).
- `LATENCY`, default 2: extra wait-state cycles per access; legal range 0..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_memory_address`  in  32  byte address from the core.
- `data_memory_write_data`  in  32  store data, already lane-aligned by the core.
- `data_memory_byte_enable`  in  4  store lane mask; bit i selects bits [8i+7:8i].
- `data_memory_write_enable`  in  1  store request.
- `data_memory_read_enable`  in  1  load request.
- `data_memory_read_data`  out  32  registered load data (full word).
- `data_memory_busy`  out  1  stall request to the core.
- `read_count`  out  32  completed loads.
- `write_count`  out  32  completed stores.

## Operation
- A request is present when `req = write_enable | read_enable`.
- Word index is `address[ADDR_WIDTH+1:2]`. `address[1:0]` and bits above the index are ignored, so upper addresses alias.
- FSM states are IDLE, WAIT and DONE.
  - IDLE: `busy = req` (combinational). If `req` is high, the block captures address, write data, byte enable and the operation type (store if `write_enable`, else load), loads `cnt <= LATENCY`, and moves to WAIT.
  - WAIT: `busy = 1`. If `cnt != 0`, decrement. If `cnt == 0`, perform the access at this edge and move to DONE.
    - Store: for each lane with its byte-enable bit set, `mem[idx]` takes the captured lane; other lanes are unchanged. A byte enable of 4'b0000 writes nothing but still completes.
    - Load: `read_data <= mem[idx]`.
  - DONE: `busy = 0`. `read_data` holds the load result. The next state is always IDLE; the request seen in DONE is not re-accepted.
- If a request is still present in the cycle after DONE (core stalled for another reason), it is re-executed as a new access. Loads and identical stores are idempotent on the scratchpad.
- Simultaneous `write_enable` and `read_enable` are treated as a store. `read_data` is not updated.
- Request inputs are sampled only in IDLE. Changes during WAIT and DONE are ignored.
- Counters: `read_count` increments on each load completion (WAIT→DONE); `write_count` increments on each store completion. Both wrap modulo 2^32.
- Memory contents are not initialised and are not cleared by reset.

## Timing
- Reset (`rst` high at an edge): state becomes IDLE, `cnt = 0`, `read_data = 0`, both counters 0.
  - `busy` is forced 0 while `rst` is high.
  - A reset during WAIT drops the pending access; no memory write occurs.
- Request first presented in IDLE cycle T:
  - `busy` is high in cycles T through T+LATENCY+1, i.e. LATENCY+2 cycles.
  - DONE is cycle T+LATENCY+2, with `busy` low. Load data is valid in that cycle and stays valid until the next load completes.
  - A store is visible to any load accepted at T+LATENCY+3 or later.
- Back-to-back requests: a new request can be accepted in the IDLE cycle T+LATENCY+3. Sustained throughput is one access per LATENCY+3 cycles.
- With LATENCY=0: busy for 2 cycles, DONE at T+2.
- Without a request, the block stays in IDLE with `busy` low; outputs hold their values.

## Test plan
- LATENCY=2. Store 0xDEADBEEF to 0x0000_0010 with byte enable 4'hF, then load 0x0000_0010 → `busy` high for exactly 4 cycles per access, load returns 0xDEADBEEF in its DONE cycle, `write_count=1`, `read_count=1`.
- Store 0x11223344 with 4'hF, then store 0x000000AA with 4'h1, then store 0xBB000000 with 4'h8, all to 0x20. Load 0x20 → 0xBB2233AA.
- ADDR_WIDTH=12. Store 0x5A5A5A5A to 0x0000_4004, then load 0x0000_0004 (alias) → 0x5A5A5A5A. Load 0x0000_0006 → same word.
- Start a store of 0xCAFEF00D to 0x40 over a prior value of 0x12345678, and assert `rst` during WAIT → `busy` drops in the reset cycle, counters read 0. A subsequent load of 0x40 returns 0x12345678.
- Simultaneous `write_enable` and `read_enable` at 0x80 with 0x0F0F0F0F → treated as a store: `write_count` increments and `read_data` is unchanged. A later load returns 0x0F0F0F0F.
- LATENCY=0. Present a held load request continuously for 9 cycles → three completions (DONE at T+2, T+5, T+8) and `read_count=3`.
